store_queue: RTL and testbench

- In-order store queue sitting between dispatch/execute and the data-memory port, downstream of the commit stage.
- Allocates an entry per dispatched store and captures address/data from the store AGU.
- Marks entries committed when commit signals a store retiring. Drains committed stores to memory, oldest first, over a valid/ready port.
- Flush discards only uncommitted entries; committed stores always reach memory.

---
 rtl/uarch_pkg.sv | 25 ++
 rtl/store_queue.sv | 155 +++++++++++++++
 tb/tb_store_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uarch_pkg.sv
// Shared microarchitecture types and sizes for the store queue and its neighbours.
package uarch_pkg;

    localparam int TAG_WIDTH     = 6;
    localparam int SQ_ENTRIES    = 8;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_DATA_BITS = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic                     valid;
        logic                     addr_rdy;
        logic                     committed;
        logic [TAG_WIDTH-1:0]     rob_tag;
        logic [CPU_ADDR_BITS-1:0] addr;
        logic [CPU_DATA_BITS-1:0] data;
        mem_size_e                size;
    } sq_entry_t;

endpackage

// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, capture from the AGU, commit in order,
// drain committed stores oldest-first to the data-memory port.
module store_queue
    import uarch_pkg::sq_entry_t, uarch_pkg::mem_size_e, uarch_pkg::TAG_WIDTH;
#(
    parameter int SQ_ENTRIES    = uarch_pkg::SQ_ENTRIES,
    parameter int CPU_ADDR_BITS = uarch_pkg::CPU_ADDR_BITS,
    parameter int CPU_DATA_BITS = uarch_pkg::CPU_DATA_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [1:0]                      sq_alloc_req,
    output logic [1:0]                      sq_alloc_gnt,
    input  logic [TAG_WIDTH-1:0]            sq_alloc_tag0,
    input  logic [TAG_WIDTH-1:0]            sq_alloc_tag1,
    input  logic                            exe_valid,
    input  logic [TAG_WIDTH-1:0]            exe_rob_tag,
    input  logic [CPU_ADDR_BITS-1:0]        exe_addr,
    input  logic [CPU_DATA_BITS-1:0]        exe_data,
    input  logic [1:0]                      exe_size,
    input  logic                            commit_store_val0,
    input  logic                            commit_store_val1,
    input  logic [TAG_WIDTH-1:0]            commit_store_id0,
    input  logic [TAG_WIDTH-1:0]            commit_store_id1,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [CPU_ADDR_BITS-1:0]        mem_req_addr,
    output logic [CPU_DATA_BITS-1:0]        mem_req_data,
    output logic [1:0]                      mem_req_size,
    output logic                            sq_empty,
    output logic [$clog2(SQ_ENTRIES):0]     sq_count
);

    localparam int IDX_W = $clog2(SQ_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Circular distance; the wrap bit makes a full queue distinguishable from empty.
    function automatic ptr_t ptr_dist(input ptr_t from, input ptr_t to);
        return to - from;
    endfunction

    sq_entry_t q [SQ_ENTRIES];

    ptr_t head, cmt, tail;
    ptr_t count, free_slots, new_cmt, alloc_ptr1, cmt_ptr1;
    logic [1:0] n_alloc, n_commit;
    logic [SQ_ENTRIES-1:0] kill, exe_hit;
    logic mem_fire;
    sq_entry_t head_e;

    always_comb begin
        count      = ptr_dist(head, tail);
        free_slots = ptr_t'(SQ_ENTRIES) - count;
        sq_alloc_gnt = 2'b00;
        if (!flush) begin
            sq_alloc_gnt[0] = sq_alloc_req[0] && (free_slots >= ptr_t'(1));
            sq_alloc_gnt[1] = sq_alloc_req[1] &&
                              (sq_alloc_req[0] ? (free_slots >= ptr_t'(2))
                                               : (free_slots >= ptr_t'(1)));
        end
        n_alloc    = {1'b0, sq_alloc_gnt[0]} + {1'b0, sq_alloc_gnt[1]};
        alloc_ptr1 = sq_alloc_req[0] ? tail + ptr_t'(1) : tail;
        n_commit   = {1'b0, commit_store_val0} + {1'b0, commit_store_val1};
        cmt_ptr1   = commit_store_val0 ? cmt + ptr_t'(1) : cmt;
        new_cmt    = cmt + ptr_t'(n_commit);
    end

    // Speculative window after this cycle's commits, and AGU tag matches.
    always_comb begin
        kill    = '0;
        exe_hit = '0;
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            kill[i] = ({1'b0, IDX_W'(i) - new_cmt[IDX_W-1:0]} < ptr_dist(new_cmt, tail));
            exe_hit[i] = q[i].valid && !q[i].committed && (q[i].rob_tag == exe_rob_tag);
        end
    end

    assign head_e        = q[head[IDX_W-1:0]];
    assign mem_req_valid = head_e.valid && head_e.committed;
    assign mem_req_addr  = head_e.addr;
    assign mem_req_data  = head_e.data;
    assign mem_req_size  = head_e.size;
    assign mem_fire      = mem_req_valid && mem_req_ready;
    assign sq_count      = count;
    assign sq_empty      = (head == tail);

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                q[i].valid     <= 1'b0;
                q[i].addr_rdy  <= 1'b0;
                q[i].committed <= 1'b0;
            end
        end else begin
            if (mem_fire) begin
                q[head[IDX_W-1:0]].valid     <= 1'b0;
                q[head[IDX_W-1:0]].committed <= 1'b0;
                head <= head + ptr_t'(1);
            end
            if (commit_store_val0) q[cmt[IDX_W-1:0]].committed      <= 1'b1;
            if (commit_store_val1) q[cmt_ptr1[IDX_W-1:0]].committed <= 1'b1;
            cmt <= new_cmt;
            if (exe_valid && !flush) begin
                for (int i = 0; i < SQ_ENTRIES; i++) begin
                    if (exe_hit[i]) begin
                        q[i].addr     <= exe_addr;
                        q[i].data     <= exe_data;
                        q[i].size     <= mem_size_e'(exe_size);
                        q[i].addr_rdy <= 1'b1;
                    end
                end
            end
            if (sq_alloc_gnt[0]) begin
                q[tail[IDX_W-1:0]].valid     <= 1'b1;
                q[tail[IDX_W-1:0]].addr_rdy  <= 1'b0;
                q[tail[IDX_W-1:0]].committed <= 1'b0;
                q[tail[IDX_W-1:0]].rob_tag   <= sq_alloc_tag0;
            end
            if (sq_alloc_gnt[1]) begin
                q[alloc_ptr1[IDX_W-1:0]].valid     <= 1'b1;
                q[alloc_ptr1[IDX_W-1:0]].addr_rdy  <= 1'b0;
                q[alloc_ptr1[IDX_W-1:0]].committed <= 1'b0;
                q[alloc_ptr1[IDX_W-1:0]].rob_tag   <= sq_alloc_tag1;
            end
            // Flush drops only the speculative tail; committed stores keep draining.
            if (flush) begin
                for (int i = 0; i < SQ_ENTRIES; i++) begin
                    if (kill[i]) q[i].valid <= 1'b0;
                end
                tail <= new_cmt;
            end else begin
                tail <= tail + ptr_t'(n_alloc);
            end
        end
    end

    // Retiring stores must match the in-order entry and already have an address.
    always_ff @(posedge clk) begin
        if (!rst && commit_store_val0) begin
            assert (q[cmt[IDX_W-1:0]].valid && q[cmt[IDX_W-1:0]].addr_rdy &&
                    q[cmt[IDX_W-1:0]].rob_tag == commit_store_id0);
        end
        if (!rst && commit_store_val1) begin
            assert (q[cmt_ptr1[IDX_W-1:0]].valid && q[cmt_ptr1[IDX_W-1:0]].addr_rdy &&
                    q[cmt_ptr1[IDX_W-1:0]].rob_tag == commit_store_id1);
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: allocation limits, commit/flush interplay, drain order and wrap.
module tb_store_queue;
    import uarch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [1:0]               sq_alloc_req;
    logic [1:0]               sq_alloc_gnt;
    logic [TAG_WIDTH-1:0]     sq_alloc_tag0, sq_alloc_tag1;
    logic                     exe_valid;
    logic [TAG_WIDTH-1:0]     exe_rob_tag;
    logic [CPU_ADDR_BITS-1:0] exe_addr;
    logic [CPU_DATA_BITS-1:0] exe_data;
    logic [1:0]               exe_size;
    logic                     commit_store_val0, commit_store_val1;
    logic [TAG_WIDTH-1:0]     commit_store_id0, commit_store_id1;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [CPU_ADDR_BITS-1:0] mem_req_addr;
    logic [CPU_DATA_BITS-1:0] mem_req_data;
    logic [1:0]               mem_req_size;
    logic                     sq_empty;
    logic [3:0]               sq_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    store_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .sq_alloc_req(sq_alloc_req), .sq_alloc_gnt(sq_alloc_gnt),
        .sq_alloc_tag0(sq_alloc_tag0), .sq_alloc_tag1(sq_alloc_tag1),
        .exe_valid(exe_valid), .exe_rob_tag(exe_rob_tag), .exe_addr(exe_addr),
        .exe_data(exe_data), .exe_size(exe_size),
        .commit_store_val0(commit_store_val0), .commit_store_val1(commit_store_val1),
        .commit_store_id0(commit_store_id0), .commit_store_id1(commit_store_id1),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_size(mem_req_size), .sq_empty(sq_empty), .sq_count(sq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #2;
    endtask

    task automatic alloc(input logic [1:0] req, input int t0, input int t1, input logic [1:0] exp_gnt);
        sq_alloc_req  = req;
        sq_alloc_tag0 = TAG_WIDTH'(t0);
        sq_alloc_tag1 = TAG_WIDTH'(t1);
        #1;
        chk("alloc_gnt", 64'(sq_alloc_gnt), 64'(exp_gnt));
        tick;
        sq_alloc_req = 2'b00;
    endtask

    task automatic exe(input int tag, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        exe_valid   = 1'b1;
        exe_rob_tag = TAG_WIDTH'(tag);
        exe_addr    = addr;
        exe_data    = data;
        exe_size    = size;
        tick;
        exe_valid = 1'b0;
    endtask

    task automatic commit(input logic v0, input int id0, input logic v1, input int id1);
        commit_store_val0 = v0;
        commit_store_id0  = TAG_WIDTH'(id0);
        commit_store_val1 = v1;
        commit_store_id1  = TAG_WIDTH'(id1);
        tick;
        commit_store_val0 = 1'b0;
        commit_store_val1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; sq_alloc_req = 2'b00;
        sq_alloc_tag0 = '0; sq_alloc_tag1 = '0;
        exe_valid = 1'b0; exe_rob_tag = '0; exe_addr = '0; exe_data = '0; exe_size = 2'd0;
        commit_store_val0 = 1'b0; commit_store_val1 = 1'b0;
        commit_store_id0 = '0; commit_store_id1 = '0;
        mem_req_ready = 1'b0;
        tick;
        tick;
        chk("rst_gnt", 64'(sq_alloc_gnt), 64'd0);
        chk("rst_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_empty", 64'(sq_empty), 64'd1);
        chk("rst_count", 64'(sq_count), 64'd0);
        rst = 1'b0;

        // Two stores, committed together, drained back to back
        alloc(2'b11, 3, 4, 2'b11);
        chk("t1_count", 64'(sq_count), 64'd2);
        chk("t1_novalid", 64'(mem_req_valid), 64'd0);
        exe(3, 32'h100, 32'hAA, 2'd2);
        exe(4, 32'h104, 32'hBB, 2'd2);
        chk("t1_precommit_valid", 64'(mem_req_valid), 64'd0);
        commit(1'b1, 3, 1'b1, 4);
        mem_req_ready = 1'b1;
        #1;
        chk("t1_valid0", 64'(mem_req_valid), 64'd1);
        chk("t1_addr0", 64'(mem_req_addr), 64'h100);
        chk("t1_data0", 64'(mem_req_data), 64'hAA);
        chk("t1_size0", 64'(mem_req_size), 64'd2);
        tick;
        chk("t1_valid1", 64'(mem_req_valid), 64'd1);
        chk("t1_addr1", 64'(mem_req_addr), 64'h104);
        chk("t1_data1", 64'(mem_req_data), 64'hBB);
        tick;
        chk("t1_empty", 64'(sq_empty), 64'd1);
        chk("t1_valid_end", 64'(mem_req_valid), 64'd0);
        mem_req_ready = 1'b0;

        // Fill to 7, probe partial grants, fill to 8, probe full
        alloc(2'b11, 10, 11, 2'b11);
        alloc(2'b11, 12, 13, 2'b11);
        alloc(2'b11, 14, 15, 2'b11);
        alloc(2'b01, 16, 0, 2'b01);
        chk("t2_count7", 64'(sq_count), 64'd7);
        sq_alloc_req = 2'b11;
        #1;
        chk("t2_gnt_7_req11", 64'(sq_alloc_gnt), 64'b01);
        sq_alloc_req = 2'b10;
        #1;
        chk("t2_gnt_7_req10", 64'(sq_alloc_gnt), 64'b10);
        sq_alloc_req = 2'b00;
        alloc(2'b01, 17, 0, 2'b01);
        chk("t2_count8", 64'(sq_count), 64'd8);
        sq_alloc_req = 2'b11;
        #1;
        chk("t2_gnt_full", 64'(sq_alloc_gnt), 64'b00);
        sq_alloc_req = 2'b00;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("t2_flush_count", 64'(sq_count), 64'd0);
        chk("t2_flush_empty", 64'(sq_empty), 64'd1);

        // Four entries, two committed, flush while drain is stalled
        alloc(2'b11, 20, 21, 2'b11);
        alloc(2'b11, 22, 23, 2'b11);
        for (int i = 0; i < 4; i++) exe(20 + i, 32'h200 + 32'(4 * i), 32'h20 + 32'(i), 2'd2);
        commit(1'b1, 20, 1'b1, 21);
        chk("t3_valid", 64'(mem_req_valid), 64'd1);
        chk("t3_addr", 64'(mem_req_addr), 64'h200);
        flush = 1'b1;
        sq_alloc_req = 2'b11;
        #1;
        chk("t3_gnt_flush", 64'(sq_alloc_gnt), 64'b00);
        tick;
        flush = 1'b0;
        sq_alloc_req = 2'b00;
        chk("t3_count", 64'(sq_count), 64'd2);
        chk("t3_valid_kept", 64'(mem_req_valid), 64'd1);
        chk("t3_addr_kept", 64'(mem_req_addr), 64'h200);
        chk("t3_data_kept", 64'(mem_req_data), 64'h20);
        mem_req_ready = 1'b1;
        tick;
        chk("t3_addr2", 64'(mem_req_addr), 64'h204);
        chk("t3_data2", 64'(mem_req_data), 64'h21);
        tick;
        chk("t3_empty", 64'(sq_empty), 64'd1);
        mem_req_ready = 1'b0;

        // Commit one plus flush in the same cycle
        alloc(2'b11, 30, 31, 2'b11);
        alloc(2'b01, 32, 0, 2'b01);
        for (int i = 0; i < 3; i++) exe(30 + i, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 2'd2);
        flush = 1'b1;
        commit(1'b1, 30, 1'b0, 0);
        flush = 1'b0;
        chk("t4_count", 64'(sq_count), 64'd1);
        chk("t4_valid", 64'(mem_req_valid), 64'd1);
        chk("t4_addr", 64'(mem_req_addr), 64'h300);
        chk("t4_data", 64'(mem_req_data), 64'h30);
        mem_req_ready = 1'b1;
        tick;
        chk("t4_empty", 64'(sq_empty), 64'd1);
        chk("t4_count0", 64'(sq_count), 64'd0);
        mem_req_ready = 1'b0;

        // Stalled drain holds payload
        alloc(2'b01, 40, 0, 2'b01);
        exe(40, 32'h400, 32'hDEAD, 2'd1);
        commit(1'b1, 40, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            chk("t5_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("t5_hold_addr", 64'(mem_req_addr), 64'h400);
            chk("t5_hold_data", 64'(mem_req_data), 64'hDEAD);
            chk("t5_hold_size", 64'(mem_req_size), 64'd1);
            tick;
        end
        mem_req_ready = 1'b1;
        tick;
        chk("t5_empty", 64'(sq_empty), 64'd1);
        mem_req_ready = 1'b0;

        // Twenty stores in pairs, crossing the pointer wrap
        for (int b = 0; b < 10; b++) begin
            alloc(2'b11, 2 * b + 1, 2 * b + 2, 2'b11);
            chk("wrap_count", 64'(sq_count), 64'd2);
            exe(2 * b + 1, 32'h1000 + 32'(8 * b), 32'hC000 + 32'(2 * b), 2'd2);
            exe(2 * b + 2, 32'h1004 + 32'(8 * b), 32'hC001 + 32'(2 * b), 2'd2);
            commit(1'b1, 2 * b + 1, 1'b1, 2 * b + 2);
            mem_req_ready = 1'b1;
            #1;
            chk("wrap_addr_a", 64'(mem_req_addr), 64'(32'h1000 + 32'(8 * b)));
            chk("wrap_data_a", 64'(mem_req_data), 64'(32'hC000 + 32'(2 * b)));
            tick;
            chk("wrap_addr_b", 64'(mem_req_addr), 64'(32'h1004 + 32'(8 * b)));
            chk("wrap_data_b", 64'(mem_req_data), 64'(32'hC001 + 32'(2 * b)));
            tick;
            chk("wrap_empty", 64'(sq_empty), 64'd1);
            mem_req_ready = 1'b0;
        end

        // Reset with a pending drain
        alloc(2'b11, 50, 51, 2'b11);
        alloc(2'b11, 52, 53, 2'b11);
        alloc(2'b01, 54, 0, 2'b01);
        exe(50, 32'h500, 32'h55, 2'd0);
        commit(1'b1, 50, 1'b0, 0);
        chk("t6_pre_valid", 64'(mem_req_valid), 64'd1);
        chk("t6_pre_count", 64'(sq_count), 64'd5);
        rst = 1'b1;
        tick;
        chk("t6_valid", 64'(mem_req_valid), 64'd0);
        chk("t6_count", 64'(sq_count), 64'd0);
        chk("t6_empty", 64'(sq_empty), 64'd1);
        rst = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed running expected done");
        $fatal(1);
    end

endmodule
